// File: rtl/dmem_io_responder.sv
// rtl/dmem_io_responder.sv - memory-mapped I/O responder (GPIO, timer) in front of dmem_sim
module dmem_io_responder #(
    parameter int                         DMEM_ADDR_WIDTH = 12,
    parameter int                         DMEM_WORD_WIDTH = 16,
    parameter logic [DMEM_ADDR_WIDTH-1:0] IO_BASE         = 12'hF00
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_addr_rd,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_addr_wr,
    input  logic                       in_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] in_word,
    output logic [DMEM_WORD_WIDTH-1:0] out_word,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr_rd,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr_wr,
    output logic                       out_mem_write_en,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_word,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_word,
    input  logic [DMEM_WORD_WIDTH-1:0] in_gpio,
    output logic [DMEM_WORD_WIDTH-1:0] out_gpio,
    output logic                       out_timer_match
);

    localparam int W = DMEM_WORD_WIDTH;

    localparam logic [2:0] SEL_GPIO_OUT  = 3'd0;
    localparam logic [2:0] SEL_GPIO_IN   = 3'd1;
    localparam logic [2:0] SEL_TIMER_CNT = 3'd2;
    localparam logic [2:0] SEL_TIMER_CMP = 3'd3;
    localparam logic [2:0] SEL_CTRL      = 3'd4;
    localparam logic [2:0] SEL_STATUS    = 3'd5;

    logic         hit_rd;
    logic         hit_wr;
    logic         io_wr;
    logic [2:0]   wr_sel;
    logic         cnt_match;
    logic [W-1:0] rd_mux;

    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_sync1;
    logic [W-1:0] gpio_sync2;
    logic [W-1:0] timer_cnt;
    logic [W-1:0] timer_cmp;
    logic         ctrl_en;
    logic         ctrl_clr;
    logic         status_match;
    logic         rd_io_sel;
    logic [W-1:0] rd_io_data;

    assign hit_rd    = in_addr_rd[DMEM_ADDR_WIDTH-1:4] == IO_BASE[DMEM_ADDR_WIDTH-1:4];
    assign hit_wr    = in_addr_wr[DMEM_ADDR_WIDTH-1:4] == IO_BASE[DMEM_ADDR_WIDTH-1:4];
    assign io_wr     = in_write_en & hit_wr;
    assign wr_sel    = in_addr_wr[3:1];
    assign cnt_match = ctrl_en & (timer_cnt == timer_cmp);

    // I/O writes are swallowed here so they never alias into DMEM
    assign out_mem_addr_rd  = in_addr_rd;
    assign out_mem_addr_wr  = in_addr_wr;
    assign out_mem_word     = in_word;
    assign out_mem_write_en = in_write_en & ~hit_wr;

    assign out_word        = rd_io_sel ? rd_io_data : in_mem_word;
    assign out_gpio        = gpio_out;
    assign out_timer_match = status_match;

    always_comb begin
        rd_mux = '0;
        case (in_addr_rd[3:1])
            SEL_GPIO_OUT:  rd_mux = gpio_out;
            SEL_GPIO_IN:   rd_mux = gpio_sync2;
            SEL_TIMER_CNT: rd_mux = timer_cnt;
            SEL_TIMER_CMP: rd_mux = timer_cmp;
            SEL_CTRL:      rd_mux = {{(W-2){1'b0}}, ctrl_clr, ctrl_en};
            SEL_STATUS:    rd_mux = {{(W-1){1'b0}}, status_match};
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gpio_out     <= '0;
            gpio_sync1   <= '0;
            gpio_sync2   <= '0;
            timer_cnt    <= '0;
            timer_cmp    <= '0;
            ctrl_en      <= 1'b0;
            ctrl_clr     <= 1'b0;
            status_match <= 1'b0;
            rd_io_sel    <= 1'b0;
            rd_io_data   <= '0;
        end else begin
            gpio_sync1 <= in_gpio;
            gpio_sync2 <= gpio_sync1;

            // rd_mux sees pre-edge state, so a same-cycle write is not visible
            rd_io_sel  <= hit_rd;
            rd_io_data <= rd_mux;

            if (io_wr && wr_sel == SEL_GPIO_OUT)  gpio_out  <= in_word;
            if (io_wr && wr_sel == SEL_TIMER_CMP) timer_cmp <= in_word;
            if (io_wr && wr_sel == SEL_CTRL) begin
                ctrl_en  <= in_word[0];
                ctrl_clr <= in_word[1];
            end

            if (io_wr && wr_sel == SEL_TIMER_CNT)
                timer_cnt <= in_word;
            else if (cnt_match && ctrl_clr)
                timer_cnt <= '0;
            else if (ctrl_en)
                timer_cnt <= timer_cnt + W'(1);

            // set beats a simultaneous write-1-to-clear
            if (cnt_match)
                status_match <= 1'b1;
            else if (io_wr && wr_sel == SEL_STATUS && in_word[0])
                status_match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_io_responder.sv
// tb/tb_dmem_io_responder.sv - scoreboard bench for dmem_io_responder with a behavioural model
module tb_dmem_io_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] in_addr_rd, in_addr_wr;
    logic        in_write_en;
    logic [15:0] in_word, out_word, out_mem_word, in_mem_word, in_gpio, out_gpio;
    logic [11:0] out_mem_addr_rd, out_mem_addr_wr;
    logic        out_mem_write_en, out_timer_match;

    always #5 clock = ~clock;

    dmem_io_responder #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .IO_BASE(12'hF00)) dut (
        .clock(clock), .reset(reset),
        .in_addr_rd(in_addr_rd), .in_addr_wr(in_addr_wr),
        .in_write_en(in_write_en), .in_word(in_word),
        .out_word(out_word),
        .out_mem_addr_rd(out_mem_addr_rd), .out_mem_addr_wr(out_mem_addr_wr),
        .out_mem_write_en(out_mem_write_en), .out_mem_word(out_mem_word),
        .in_mem_word(in_mem_word),
        .in_gpio(in_gpio), .out_gpio(out_gpio), .out_timer_match(out_timer_match)
    );

    function automatic logic [15:0] init_word(input logic [11:0] a);
        return 16'h5A00 ^ {4'h0, a};
    endfunction

    function automatic bit is_io(input logic [11:0] a);
        return a[11:4] == 8'hF0;
    endfunction

    // dmem_sim stand-in: synchronous read, read-before-write
    bit   [15:0] dmem [4096];
    bit          dmem_vld [4096];
    always @(posedge clock) begin
        if (out_mem_write_en) begin
            dmem[out_mem_addr_wr]     <= out_mem_word;
            dmem_vld[out_mem_addr_wr] <= 1'b1;
        end
        in_mem_word <= dmem_vld[out_mem_addr_rd] ? dmem[out_mem_addr_rd] : init_word(out_mem_addr_rd);
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [15:0] m_mem [4096];
    bit          m_vld [4096];
    logic [15:0] m_gpio_out, m_cnt, m_cmp, hist1, hist2;
    bit          m_en, m_clr, m_match;
    logic [15:0] cur_gpio;
    logic [11:0] last_ra;

    typedef struct {
        int          due;
        logic [15:0] word;
        logic [15:0] gpio;
        logic        match;
    } exp_t;
    exp_t q[$];

    task automatic model_reset();
        m_gpio_out = '0; m_cnt = '0; m_cmp = '0;
        m_en = 0; m_clr = 0; m_match = 0;
        hist1 = '0; hist2 = '0;
    endtask

    function automatic logic [15:0] model_passthru(input logic [11:0] a);
        return m_vld[a] ? m_mem[a] : init_word(a);
    endfunction

    function automatic logic [15:0] model_read(input logic [11:0] a);
        if (!is_io(a)) return model_passthru(a);
        case (a[3:1])
            3'd0: return m_gpio_out;
            3'd1: return hist2;
            3'd2: return m_cnt;
            3'd3: return m_cmp;
            3'd4: return {14'b0, m_clr, m_en};
            3'd5: return {15'b0, m_match};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic do_cycle(input logic [11:0] ra, input logic [11:0] wa, input bit we, input logic [15:0] wd);
        exp_t        e;
        bit          wr_hit, mnow;
        logic [2:0]  s;
        logic [15:0] ncnt;
        @(posedge clock);
        #2;
        in_addr_rd = ra; in_addr_wr = wa; in_write_en = we; in_word = wd; in_gpio = cur_gpio;
        last_ra = ra;
        #1;
        check("mem_write_en", {31'b0, out_mem_write_en}, {31'b0, we && !is_io(wa)});
        check("mem_addr_rd", {20'b0, out_mem_addr_rd}, {20'b0, ra});
        e.due  = cyc + 1;
        e.word = model_read(ra);
        wr_hit = we && is_io(wa);
        s      = wa[3:1];
        mnow   = m_en && (m_cnt == m_cmp);
        ncnt   = m_cnt;
        if (wr_hit && s == 3'd2) ncnt = wd;
        else if (mnow && m_clr)  ncnt = 16'h0000;
        else if (m_en)           ncnt = m_cnt + 16'd1;
        if (wr_hit && s == 3'd0) m_gpio_out = wd;
        if (wr_hit && s == 3'd3) m_cmp = wd;
        if (wr_hit && s == 3'd4) begin m_en = wd[0]; m_clr = wd[1]; end
        if (mnow) m_match = 1;
        else if (wr_hit && s == 3'd5 && wd[0]) m_match = 0;
        m_cnt = ncnt;
        if (we && !is_io(wa)) begin m_mem[wa] = wd; m_vld[wa] = 1; end
        hist2 = hist1;
        hist1 = cur_gpio;
        e.gpio  = m_gpio_out;
        e.match = m_match;
        q.push_back(e);
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d, input logic [11:0] ra = 12'hF04);
        do_cycle(ra, a, 1'b1, d);
    endtask

    task automatic rd(input logic [11:0] a);
        do_cycle(a, 12'h000, 1'b0, 16'h0000);
    endtask

    task automatic reset_mid();
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("rst_out_word", {16'b0, out_word}, {16'b0, model_passthru(last_ra)});
        check("rst_out_gpio", {16'b0, out_gpio}, 32'h0);
        check("rst_match", {31'b0, out_timer_match}, 32'h0);
        q.delete();
        model_reset();
        in_write_en = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("out_word", {16'b0, out_word}, {16'b0, e.word});
                check("out_gpio", {16'b0, out_gpio}, {16'b0, e.gpio});
                check("out_timer_match", {31'b0, out_timer_match}, {31'b0, e.match});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [11:0] ra, wa;
        logic [15:0] wd;
        bit          we;
        reset = 1'b1;
        in_addr_rd = 12'h000; in_addr_wr = 12'hF00; in_write_en = 1'b1;
        in_word = 16'hFFFF; in_gpio = 16'h0000; cur_gpio = 16'h0000;
        last_ra = 12'h000;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        check("reset_gpio", {16'b0, out_gpio}, 32'h0);
        check("reset_match", {31'b0, out_timer_match}, 32'h0);
        check("reset_out_word", {16'b0, out_word}, {16'b0, init_word(12'h000)});
        check("reset_io_we_blocked", {31'b0, out_mem_write_en}, 32'h0);
        in_addr_wr = 12'h010;
        #1;
        check("reset_mem_we_pass", {31'b0, out_mem_write_en}, 32'h1);
        in_write_en = 1'b0;
        reset = 1'b0;

        // pass-through
        do_cycle(12'h000, 12'h010, 1'b1, 16'h1234);
        rd(12'h010);
        // GPIO out, then synchronized GPIO in
        wr(12'hF00, 16'hA5A5, 12'hF00);
        rd(12'hF00);
        cur_gpio = 16'h00FF;
        rd(12'hF02); rd(12'hF02); rd(12'hF02); rd(12'hF02);
        // timer match with clear-on-match
        wr(12'hF04, 16'h0000);
        wr(12'hF06, 16'h0005);
        wr(12'hF08, 16'h0003);
        repeat (14) rd(12'hF04);
        // W1C collision: match every cycle, then with the timer stopped
        wr(12'hF06, 16'h0000);
        repeat (3) rd(12'hF04);
        wr(12'hF0A, 16'h0001, 12'hF0A);
        rd(12'hF0A);
        wr(12'hF08, 16'h0000);
        rd(12'hF0A);
        wr(12'hF0A, 16'h0001, 12'hF0A);
        rd(12'hF0A);
        // priority and wrap
        wr(12'hF06, 16'h0000);
        wr(12'hF08, 16'h0001);
        wr(12'hF04, 16'hFFFE);
        repeat (3) rd(12'hF04);
        wr(12'hF04, 16'h0100);
        repeat (2) rd(12'hF04);
        // same-cycle read and write of one register returns the old value
        wr(12'hF06, 16'h0042, 12'hF06);
        rd(12'hF06);
        // reset during an in-flight I/O read
        rd(12'hF04);
        reset_mid();
        rd(12'hF04);
        rd(12'hF08);

        for (int i = 0; i < 400; i++) begin
            ra = ($urandom % 2) ? {8'hF0, 4'($urandom)} : 12'($urandom_range(0, 255));
            wa = ($urandom % 2) ? {8'hF0, 4'($urandom)} : 12'($urandom_range(0, 255));
            we = ($urandom % 3) != 0;
            wd = 16'($urandom);
            if (is_io(wa) && wa[3:1] == 3'd4) wd = {14'($urandom), 1'b0 + 1'($urandom), ($urandom % 4) != 0};
            if (is_io(wa) && (wa[3:1] == 3'd2 || wa[3:1] == 3'd3) && ($urandom % 2)) wd = 16'($urandom_range(0, 12));
            if ($urandom % 8 == 0) cur_gpio = 16'($urandom);
            do_cycle(ra, wa, we, wd);
            if (i == 200) reset_mid();
        end

        in_write_en = 1'b0;
        repeat (4) @(negedge clock);
        check("scoreboard_drained", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
